// File: rtl/cp_pkg.sv
//============================================================================
// Module  : cp_pkg
// Brief   : Shared types, widths and the range-invalidate mask helper for
//           the branch-recovery checkpoint manager.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 8
`endif
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef ST_B_LENGTH
`define ST_B_LENGTH 8
`endif

package cp_pkg;

    localparam int CP_NUM   = 4;
    localparam int CP_TAG_W = $clog2(CP_NUM);
    localparam int CP_NUM_D = `NUM_D_REG;
    localparam int CP_NUM_S = `NUM_S_REG;
    localparam int CP_D_W   = $clog2(`NUM_D_REG);
    localparam int CP_S_W   = $clog2(`NUM_S_REG);
    localparam int CP_ROB_W = $clog2(`ROB_LENGTH);
    localparam int CP_SB_W  = $clog2(`ST_B_LENGTH);

    typedef logic [CP_TAG_W-1:0] cp_tag_t;

    typedef struct packed {
        logic                     valid;
        logic                     resolved;
        logic [15:0][CP_D_W-1:0]  d_translation;
        logic [CP_S_W-1:0]        s_translation;
        logic [CP_NUM_D-1:0]      r_free_list;
        logic [CP_NUM_S-1:0]      s_free_list;
        logic [CP_ROB_W-1:0]      rob_tail;
        logic [CP_SB_W-1:0]       sb_tail;
    } cp_entry_t;

    // Slots from 'first' up to but not including 'stop', wrapping around the
    // ring. first == stop only happens when the ring is full, so every slot.
    function automatic logic [CP_NUM-1:0] cp_range_mask(input cp_tag_t first,
                                                        input cp_tag_t stop);
        logic [CP_NUM-1:0] mask;
        cp_tag_t           len;
        cp_tag_t           off;
        mask = '0;
        len  = stop - first;
        for (int i = 0; i < CP_NUM; i++) begin
            off     = cp_tag_t'(i) - first;
            mask[i] = (len == '0) || (off < len);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/checkpoint_manager.sv
//============================================================================
// Module  : checkpoint_manager
// Brief   : Circular store of branch checkpoints (rename tables, free lists,
//           ROB/SB tails). Allocates on dispatch, retires on correct
//           resolve, squashes and restores on mispredict.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module checkpoint_manager
    import cp_pkg::*;
#(
    parameter int NUM_CP     = CP_NUM,
    parameter int NUM_D_REG  = CP_NUM_D,
    parameter int NUM_S_REG  = CP_NUM_S,
    parameter int ROB_LENGTH = `ROB_LENGTH,
    parameter int SB_LENGTH  = `ST_B_LENGTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alloc_valid,
    output logic                                 alloc_ready,
    output logic [$clog2(NUM_CP)-1:0]            alloc_tag,
    input  logic [15:0][$clog2(NUM_D_REG)-1:0]   snap_d_translation,
    input  logic [$clog2(NUM_S_REG)-1:0]         snap_s_translation,
    input  logic [NUM_D_REG-1:0]                 snap_r_free_list,
    input  logic [NUM_S_REG-1:0]                 snap_s_free_list,
    input  logic [$clog2(ROB_LENGTH)-1:0]        snap_rob_tail,
    input  logic [$clog2(SB_LENGTH)-1:0]         snap_sb_tail,
    input  logic                                 resolve_valid,
    input  logic [$clog2(NUM_CP)-1:0]            resolve_tag,
    input  logic                                 resolve_mispredict,
    input  logic                                 commit_free_valid,
    input  logic [$clog2(NUM_D_REG)-1:0]         commit_free_preg,
    input  logic                                 flush,
    output logic                                 restore_valid,
    output logic [15:0][$clog2(NUM_D_REG)-1:0]   restore_d_translation,
    output logic [$clog2(NUM_S_REG)-1:0]         restore_s_translation,
    output logic [NUM_D_REG-1:0]                 restore_r_free_list,
    output logic [NUM_S_REG-1:0]                 restore_s_free_list,
    output logic [$clog2(ROB_LENGTH)-1:0]        restore_rob_tail,
    output logic [$clog2(SB_LENGTH)-1:0]         restore_sb_tail,
    output logic [$clog2(NUM_CP):0]              cp_count
);

    localparam int CNT_W = CP_TAG_W + 1;

    cp_entry_t            r_slots [NUM_CP];
    cp_tag_t              r_head;
    cp_tag_t              r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 w_full;
    logic                 w_alloc;
    logic                 w_mispredict;
    logic                 w_resolve_ok;
    logic                 w_retire;
    logic [NUM_CP-1:0]    w_inv_mask;
    logic [NUM_D_REG-1:0] w_commit_vec;
    cp_entry_t            w_new_entry;

    assign w_full       = (r_count == CNT_W'(NUM_CP));
    assign alloc_ready  = ~w_full & ~flush & ~(resolve_valid & resolve_mispredict);
    assign alloc_tag    = r_tail;
    assign cp_count     = r_count;
    assign w_alloc      = alloc_valid & alloc_ready;
    assign w_mispredict = ~flush & resolve_valid & resolve_mispredict & r_slots[resolve_tag].valid;
    assign w_resolve_ok = ~flush & resolve_valid & ~resolve_mispredict & r_slots[resolve_tag].valid;
    assign w_retire     = ~flush & r_slots[r_head].valid & r_slots[r_head].resolved;
    assign w_inv_mask   = cp_range_mask(resolve_tag, r_tail);

    // One-hot of the register commit is returning to the free list this cycle
    always_comb begin
        w_commit_vec = '0;
        if (commit_free_valid) begin
            w_commit_vec[commit_free_preg] = 1'b1;
        end
    end

    // Snapshot as it will be written into the allocated slot
    always_comb begin
        w_new_entry               = '0;
        w_new_entry.valid         = 1'b1;
        w_new_entry.resolved      = 1'b0;
        w_new_entry.d_translation = snap_d_translation;
        w_new_entry.s_translation = snap_s_translation;
        w_new_entry.r_free_list   = snap_r_free_list | w_commit_vec;
        w_new_entry.s_free_list   = snap_s_free_list;
        w_new_entry.rob_tail      = snap_rob_tail;
        w_new_entry.sb_tail       = snap_sb_tail;
    end

    // Slot storage: commit-free merge, squash, retire, resolve and allocate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CP; i++) begin
                r_slots[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_CP; i++) begin
                r_slots[i].valid    <= 1'b0;
                r_slots[i].resolved <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CP; i++) begin
                if (r_slots[i].valid && commit_free_valid) begin
                    r_slots[i].r_free_list[commit_free_preg] <= 1'b1;
                end
                if (w_mispredict && w_inv_mask[i]) begin
                    r_slots[i].valid    <= 1'b0;
                    r_slots[i].resolved <= 1'b0;
                end else if (w_retire && (cp_tag_t'(i) == r_head)) begin
                    r_slots[i].valid    <= 1'b0;
                    r_slots[i].resolved <= 1'b0;
                end else if (w_resolve_ok && (cp_tag_t'(i) == resolve_tag)) begin
                    r_slots[i].resolved <= 1'b1;
                end
                // Allocation never coincides with a mispredict (alloc_ready is low)
                if (w_alloc && (cp_tag_t'(i) == r_tail)) begin
                    r_slots[i] <= w_new_entry;
                end
            end
        end
    end

    // Ring pointers and live-slot count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispredict) begin
            // Survivors are exactly [head, resolve_tag); head may still retire
            r_tail  <= resolve_tag;
            r_head  <= r_head + cp_tag_t'(w_retire);
            r_count <= {1'b0, cp_tag_t'(resolve_tag - r_head)} - CNT_W'(w_retire);
        end else begin
            r_head  <= r_head + cp_tag_t'(w_retire);
            r_tail  <= r_tail + cp_tag_t'(w_alloc);
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_retire);
        end
    end

    // Restore pulse and held payload toward the hazard controller
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restore_valid         <= 1'b0;
            restore_d_translation <= '0;
            restore_s_translation <= '0;
            restore_r_free_list   <= '0;
            restore_s_free_list   <= '0;
            restore_rob_tail      <= '0;
            restore_sb_tail       <= '0;
        end else begin
            restore_valid <= w_mispredict;
            if (w_mispredict) begin
                restore_d_translation <= r_slots[resolve_tag].d_translation;
                restore_s_translation <= r_slots[resolve_tag].s_translation;
                restore_r_free_list   <= r_slots[resolve_tag].r_free_list | w_commit_vec;
                restore_s_free_list   <= r_slots[resolve_tag].s_free_list;
                restore_rob_tail      <= r_slots[resolve_tag].rob_tail;
                restore_sb_tail       <= r_slots[resolve_tag].sb_tail;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_checkpoint_manager.sv
//============================================================================
// Module  : tb_checkpoint_manager
// Brief   : Self-checking bench for checkpoint_manager against an ordered
//           list-of-live-branches reference model.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_checkpoint_manager;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [1:0]       alloc_tag;
    logic [15:0][4:0] snap_d_translation;
    logic [2:0]       snap_s_translation;
    logic [31:0]      snap_r_free_list;
    logic [7:0]       snap_s_free_list;
    logic [3:0]       snap_rob_tail;
    logic [2:0]       snap_sb_tail;
    logic             resolve_valid;
    logic [1:0]       resolve_tag;
    logic             resolve_mispredict;
    logic             commit_free_valid;
    logic [4:0]       commit_free_preg;
    logic             flush;
    logic             restore_valid;
    logic [15:0][4:0] restore_d_translation;
    logic [2:0]       restore_s_translation;
    logic [31:0]      restore_r_free_list;
    logic [7:0]       restore_s_free_list;
    logic [3:0]       restore_rob_tail;
    logic [2:0]       restore_sb_tail;
    logic [2:0]       cp_count;

    checkpoint_manager dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .snap_d_translation(snap_d_translation), .snap_s_translation(snap_s_translation),
        .snap_r_free_list(snap_r_free_list), .snap_s_free_list(snap_s_free_list),
        .snap_rob_tail(snap_rob_tail), .snap_sb_tail(snap_sb_tail),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
        .flush(flush),
        .restore_valid(restore_valid),
        .restore_d_translation(restore_d_translation),
        .restore_s_translation(restore_s_translation),
        .restore_r_free_list(restore_r_free_list),
        .restore_s_free_list(restore_s_free_list),
        .restore_rob_tail(restore_rob_tail), .restore_sb_tail(restore_sb_tail),
        .cp_count(cp_count)
    );

    always #5 clk = ~clk;

    // Reference model: live branches oldest-first, each with its snapshot
    typedef struct {
        logic [1:0]  tag;
        logic        resolved;
        logic [79:0] dt;
        logic [2:0]  st;
        logic [31:0] rfl;
        logic [7:0]  sfl;
        logic [3:0]  rob;
        logic [2:0]  sb;
    } m_ent_t;

    m_ent_t     q[$];
    logic [1:0] m_tail;
    logic       exp_rv;
    m_ent_t     exp_pl;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 2'd0;
        exp_rv = 1'b0;
        exp_pl = '{default: '0};
    endtask

    task automatic set_idle();
        alloc_valid        = 1'b0;
        resolve_valid      = 1'b0;
        resolve_tag        = 2'd0;
        resolve_mispredict = 1'b0;
        commit_free_valid  = 1'b0;
        commit_free_preg   = 5'd0;
        flush              = 1'b0;
    endtask

    function automatic int find_tag(input logic [1:0] t);
        int k;
        k = -1;
        foreach (q[i]) if (q[i].tag == t) k = i;
        return k;
    endfunction

    // One clock: check combinational outputs, advance the model, check state
    task automatic step();
        logic   exp_ready;
        logic   ret;
        logic   mis;
        int     k;
        m_ent_t e;
        exp_ready = (q.size() < 4) && !flush && !(resolve_valid && resolve_mispredict);
        #1;
        check("alloc_ready", alloc_ready, exp_ready);
        check("alloc_tag", alloc_tag, m_tail);
        if (flush) begin
            q.delete();
            m_tail = 2'd0;
            exp_rv = 1'b0;
        end else begin
            k   = find_tag(resolve_tag);
            ret = (q.size() > 0) && q[0].resolved;
            mis = resolve_valid && resolve_mispredict && (k >= 0);
            exp_rv = 1'b0;
            if (commit_free_valid) begin
                foreach (q[i]) begin
                    e = q[i];
                    e.rfl[commit_free_preg] = 1'b1;
                    q[i] = e;
                end
            end
            if (mis) begin
                exp_pl = q[k];
                exp_rv = 1'b1;
                while (q.size() > k) void'(q.pop_back());
                m_tail = resolve_tag;
            end else if (resolve_valid && !resolve_mispredict && k >= 0) begin
                e = q[k];
                e.resolved = 1'b1;
                q[k] = e;
            end
            if (ret) void'(q.pop_front());
            if (alloc_valid && exp_ready) begin
                e.tag      = m_tail;
                e.resolved = 1'b0;
                e.dt       = snap_d_translation;
                e.st       = snap_s_translation;
                e.rfl      = snap_r_free_list;
                if (commit_free_valid) e.rfl[commit_free_preg] = 1'b1;
                e.sfl      = snap_s_free_list;
                e.rob      = snap_rob_tail;
                e.sb       = snap_sb_tail;
                q.push_back(e);
                m_tail = m_tail + 2'd1;
            end
        end
        @(posedge clk);
        #1;
        check("restore_valid", restore_valid, exp_rv);
        check("cp_count", cp_count, q.size());
        check("restore_rob_tail", restore_rob_tail, exp_pl.rob);
        check("restore_sb_tail", restore_sb_tail, exp_pl.sb);
        check("restore_r_free_list", restore_r_free_list, exp_pl.rfl);
        check("restore_s_free_list", restore_s_free_list, exp_pl.sfl);
        check("restore_s_translation", restore_s_translation, exp_pl.st);
        check("restore_d_translation", restore_d_translation, exp_pl.dt);
        @(negedge clk);
    endtask

    task automatic rand_snap();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        snap_d_translation = w[79:0];
        snap_s_translation = 3'($urandom_range(0, 7));
        snap_r_free_list   = $urandom();
        snap_s_free_list   = 8'($urandom_range(0, 255));
        snap_rob_tail      = 4'($urandom_range(0, 15));
        snap_sb_tail       = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int k;
        set_idle();
        rand_snap();
        snap_r_free_list = 32'd0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_cp_count", cp_count, 3'd0);
        check("reset_restore_valid", restore_valid, 1'b0);
        check("reset_rob_tail", restore_rob_tail, 4'd0);
        check("reset_alloc_tag", alloc_tag, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        // Four allocations fill the ring, a fifth is refused
        for (int i = 0; i < 5; i++) begin
            alloc_valid   = 1'b1;
            snap_rob_tail = 4'(3 + 2 * i);
            step();
        end
        check("full_cp_count", cp_count, 3'd4);
        alloc_valid = 1'b0;

        // Resolve 1 then 0: head retires 0 and 1 on consecutive cycles
        resolve_valid = 1'b1; resolve_tag = 2'd1; step();
        resolve_tag = 2'd0; step();
        resolve_valid = 1'b0; step();
        step();

        // Commit frees reg 6 after snapshots with empty free lists
        commit_free_valid = 1'b1; commit_free_preg = 5'd6; step();
        commit_free_valid = 1'b0;

        // Mispredict on tag 2 together with an alloc request
        alloc_valid = 1'b1; resolve_valid = 1'b1; resolve_tag = 2'd2;
        resolve_mispredict = 1'b1; step();
        set_idle(); step();
        check("bit6_restored", restore_r_free_list[6], 1'b1);

        // Wrap: fill from tag 2 around to tag 1, then mispredict on tag 0
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; rand_snap(); step();
        end
        alloc_valid = 1'b0;
        resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = 2'd0; step();
        set_idle(); flush = 1'b1; step();
        set_idle(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_snap();
            alloc_valid        = ($urandom_range(0, 9) < 6);
            resolve_valid      = ($urandom_range(0, 9) < 4);
            resolve_tag        = 2'($urandom_range(0, 3));
            resolve_mispredict = ($urandom_range(0, 9) < 2);
            k = find_tag(resolve_tag);
            if (k >= 0 && q[k].resolved) resolve_mispredict = 1'b0;
            commit_free_valid  = ($urandom_range(0, 1) == 1);
            commit_free_preg   = 5'($urandom_range(0, 31));
            flush              = ($urandom_range(0, 99) < 2);
            step();
            if (n == 1500) begin
                // Asynchronous reset between clock edges
                #3 rst = 1'b1;
                #1;
                check("async_rst_cp_count", cp_count, 3'd0);
                check("async_rst_restore_valid", restore_valid, 1'b0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/checkpoint_manager.md
Name: checkpoint_manager

Overview:
- Owns the branch-recovery checkpoint storage for the out-of-order core.
- On each branch dispatch it allocates a slot and snapshots the translation table, both free lists, the ROB tail and the store-buffer tail.
- Frees slots as branches resolve correctly. On a mispredict it squashes the mispredicted slot and every younger slot, then drives the restore interfaces to the hazard controller.
- Sits between the decoder/rename stage, the branch unit and the hazard controller.

Parameters:
- NUM_CP, 4, number of checkpoint slots; must be a power of 2 and at least 2.
- NUM_D_REG, `NUM_D_REG, number of physical data registers.
- NUM_S_REG, `NUM_S_REG, number of physical status registers.
- ROB_LENGTH, `ROB_LENGTH, number of ROB entries.
- SB_LENGTH, `ST_B_LENGTH, number of store-buffer entries.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  a branch is dispatching this cycle; snapshot inputs are valid
- alloc_ready  out  1  a slot is available this cycle
- alloc_tag  out  $clog2(NUM_CP)  tag given to the dispatching branch
- snap_d_translation  in  16 x $clog2(NUM_D_REG)  current data-register translation table
- snap_s_translation  in  $clog2(NUM_S_REG)  current status-register translation
- snap_r_free_list  in  NUM_D_REG x 1  current data free list
- snap_s_free_list  in  NUM_S_REG x 1  current status free list
- snap_rob_tail  in  $clog2(ROB_LENGTH)  current ROB tail
- snap_sb_tail  in  $clog2(SB_LENGTH)  current store-buffer tail
- resolve_valid  in  1  the branch unit resolves a branch this cycle
- resolve_tag  in  $clog2(NUM_CP)  tag of the resolving branch
- resolve_mispredict  in  1  the resolving branch mispredicted
- commit_free_valid  in  1  commit is freeing a data physical register this cycle
- commit_free_preg  in  $clog2(NUM_D_REG)  index of the register being freed
- flush  in  1  global flush (interrupt or halt); discards all checkpoints
- restore_valid  out  1  one-cycle restore pulse
- restore_d_translation, restore_s_translation, restore_r_free_list, restore_s_free_list, restore_rob_tail, restore_sb_tail  out  same widths as the matching snap_* inputs  restore payload
- cp_count  out  $clog2(NUM_CP)+1  number of live checkpoints

Behaviour:
- Reset: head=0, tail=0, cp_count=0, all valid/resolved bits 0, restore_valid=0, all restore payload outputs 0.
- Reset asserted mid-operation clears all state immediately; no restore pulse is generated.
- Storage is circular. Tags are slot indices. head is the oldest live slot, tail is the next slot to allocate. Pointers wrap modulo NUM_CP.
- alloc_ready = (cp_count < NUM_CP) & ~flush & ~(resolve_valid & resolve_mispredict). This is combinational from registered state and current-cycle inputs.
- alloc_tag = tail.
- Allocation happens on alloc_valid & alloc_ready:
  - the slot stores the snapshot,
  - the stored free list additionally ORs in the commit_free_preg bit if commit_free_valid is high that cycle,
  - valid=1, resolved=0, tail+1.
- Commit free: every live slot ORs bit commit_free_preg into its stored r_free_list on the same clock edge. This keeps registers retired after the snapshot from leaking.
- Correct resolve (resolve_valid & ~resolve_mispredict, and slot valid): set resolved=1. A resolve on an invalid slot is ignored.
- Retirement: each cycle, if slot[head] is valid & resolved, clear it, head+1, cp_count-1. At most one slot retires per cycle.
- Mispredict (resolve_valid & resolve_mispredict, slot valid):
  - tail <= resolve_tag,
  - invalidate the slot at resolve_tag and every slot from resolve_tag up to (not including) the old tail, with wrap,
  - cp_count <= live slots in [head, resolve_tag).
  - Next cycle: restore_valid=1 with the payload from that slot. The payload r_free_list also ORs in the commit free of the mispredict cycle.
  - A mispredict on an invalid slot is ignored.
- Retiring the mispredicted slot itself at head is impossible, because it is unresolved.
- A mispredict and a head retirement in the same cycle are both applied.
- flush: invalidate all slots, head=tail=0, cp_count=0, no restore pulse. flush has priority over mispredict, and mispredict has priority over alloc.
- restore_valid is high for exactly one cycle per mispredict. Payload outputs hold their last value otherwise.
- Full (cp_count == NUM_CP): alloc_ready=0. A slot freed by retirement in this cycle is not visible until the next cycle; there is no bypass.

Decomposition:
- cp_pkg holds:
  - cp_tag_t,
  - cp_entry_t (a struct of all snapshot fields plus the valid and resolved bits),
  - the CP_TAG_W constant.
- The hazard controller consumes the restore outputs through the tt_checkpoint, frl_checkpoint, rob_checkpoint and sb_checkpoint interfaces.
- No sub-module is needed. The range-invalidate mask generator is a function in cp_pkg.

Test Plan:
- Reset, then 4 allocations with rob_tail 3,5,7,9 -> alloc_tag 0,1,2,3; cp_count=4; alloc_ready=0; a 5th alloc_valid is ignored.
- Resolve tag 1 correct, then tag 0 correct -> head retires 0 and then 1 on consecutive cycles; cp_count 4→3→2.
- Mispredict on tag 1 with tags 0..3 live -> next cycle restore_valid=1, restore_rob_tail=5, cp_count=1, tail=1; next alloc_tag=1.
- Snapshot with r_free_list all 0, then commit_free_preg=6, then mispredict -> restore_r_free_list bit 6 = 1.
- alloc_valid and mispredict in the same cycle -> alloc_ready=0, no slot allocated, restore proceeds normally.
- Wrap case: head=3, tail=1, mispredict on tag 0 -> slot 0 invalidated, tail=0, cp_count=1; flush next cycle -> cp_count=0, no restore pulse.
